// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: 50%-duty toggle or single-cycle pulse output,
// with ratio/mode reloads that only take effect at period boundaries.
module clock_divider_prog #(
  parameter int                   CNT_WIDTH   = 9,
  parameter logic [CNT_WIDTH-1:0] RESET_RATIO = '0,
  parameter logic                 INIT_LEVEL  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enabled,
  input  logic [CNT_WIDTH-1:0] div_ratio,
  input  logic                 mode_sel,
  input  logic                 load,
  output logic                 clk_div,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] ratio_active,
  output logic                 pending
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_ratioActive;
  logic                 r_modeActive;
  logic [CNT_WIDTH-1:0] r_pendRatio;
  logic                 r_pendMode;
  logic                 r_pending;
  logic                 r_clkDiv;
  logic                 r_tick;

  logic w_term;
  logic w_boundary;

  // A disabled cycle is treated as a boundary so queued settings are never stuck.
  always_comb begin
    w_term     = enabled && (r_cnt == r_ratioActive);
    w_boundary = w_term || !enabled;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (enabled) begin
      r_cnt <= w_term ? '0 : r_cnt + CNT_WIDTH'(1);
    end else if (r_pending || load) begin
      r_cnt <= '0;
    end
  end

  // A load coinciding with a boundary bypasses the pending stage entirely.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ratioActive <= RESET_RATIO;
      r_modeActive  <= 1'b0;
      r_pendRatio   <= RESET_RATIO;
      r_pendMode    <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      if (load) begin
        r_pendRatio <= div_ratio;
        r_pendMode  <= mode_sel;
      end
      if (load && w_boundary) begin
        r_ratioActive <= div_ratio;
        r_modeActive  <= mode_sel;
        r_pending     <= 1'b0;
      end else if (r_pending && w_boundary) begin
        r_ratioActive <= r_pendRatio;
        r_modeActive  <= r_pendMode;
        r_pending     <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clkDiv <= INIT_LEVEL;
      r_tick   <= 1'b0;
    end else if (enabled) begin
      r_tick <= w_term;
      if (r_modeActive) begin
        r_clkDiv <= w_term;
      end else if (w_term) begin
        r_clkDiv <= ~r_clkDiv;
      end
    end else begin
      r_tick <= 1'b0;
      if (r_modeActive) begin
        r_clkDiv <= 1'b0;
      end
    end
  end

  assign clk_div      = r_clkDiv;
  assign tick         = r_tick;
  assign ratio_active = r_ratioActive;
  assign pending      = r_pending;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: stimulus queues hand-derived expected
// outputs per clock, an independent monitor pops and compares them.
module tb_clock_divider_prog;

  localparam int W = 9;

  logic         clock = 1'b0;
  logic         reset;
  logic         enabled;
  logic         load;
  logic         mode_sel;
  logic [W-1:0] div_ratio;
  logic         clk_div;
  logic         tick;
  logic         pending;
  logic [W-1:0] ratio_active;

  typedef struct {
    logic         clkDiv;
    logic         tick;
    logic         pend;
    logic [W-1:0] ratio;
    string        name;
  } exp_t;

  exp_t sbQueue[$];
  int   total = 0;
  int   bad   = 0;

  logic         eClk;
  logic         ePend;
  logic [W-1:0] eRatio;

  clock_divider_prog #(
    .CNT_WIDTH  (W),
    .RESET_RATIO(9'd0),
    .INIT_LEVEL (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enabled     (enabled),
    .div_ratio   (div_ratio),
    .mode_sel    (mode_sel),
    .load        (load),
    .clk_div     (clk_div),
    .tick        (tick),
    .ratio_active(ratio_active),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic en, input logic ld, input logic [W-1:0] r,
                               input logic m);
    enabled   = en;
    load      = ld;
    div_ratio = r;
    mode_sel  = m;
  endtask

  task automatic pushExpected(input logic eTick, input string name);
    exp_t e;
    e.clkDiv = eClk;
    e.tick   = eTick;
    e.pend   = ePend;
    e.ratio  = eRatio;
    e.name   = name;
    sbQueue.push_back(e);
  endtask

  // Expected values describe the state just after the coming rising edge.
  task automatic expectNext(input logic eTick, input string name);
    @(posedge clock);
    pushExpected(eTick, name);
    @(negedge clock);
    #2;
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if ({clk_div, tick, pending, ratio_active} !== {e.clkDiv, e.tick, e.pend, e.ratio}) begin
      bad++;
      $display("[TB] FAIL %s: got clk_div=%b tick=%b pending=%b ratio=%0d, want clk_div=%b tick=%b pending=%b ratio=%0d",
               e.name, clk_div, tick, pending, ratio_active, e.clkDiv, e.tick, e.pend, e.ratio);
    end
  endtask

  // Monitor wakes on every falling clock edge and on reset assertion.
  initial begin
    forever begin
      @(negedge clock or negedge reset);
      #1;
      if (sbQueue.size() != 0) begin
        checkOutput(sbQueue.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    eClk   = 1'b1;
    ePend  = 1'b0;
    eRatio = 9'd0;
    repeat (2) expectNext(1'b0, "resetState");

    // R=0 toggle: output flips every clock.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      eClk = ~eClk;
      expectNext(1'b1, "r0Toggle");
    end

    // Reload mid-period, including an overwrite of the pending value.
    applyStimulus(1'b1, 1'b1, 9'd2, 1'b0);
    eClk   = ~eClk;
    eRatio = 9'd2;
    expectNext(1'b1, "bypassR2");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    repeat (2) expectNext(1'b0, "r2Hold");
    eClk = ~eClk;
    expectNext(1'b1, "r2Edge");
    applyStimulus(1'b1, 1'b1, 9'd3, 1'b0);
    ePend = 1'b1;
    expectNext(1'b0, "pendSet");
    applyStimulus(1'b1, 1'b1, 9'd4, 1'b0);
    expectNext(1'b0, "pendOverwrite");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    ePend  = 1'b0;
    eRatio = 9'd4;
    eClk   = ~eClk;
    expectNext(1'b1, "applyR4");
    repeat (2) begin
      repeat (4) expectNext(1'b0, "r4Hold");
      eClk = ~eClk;
      expectNext(1'b1, "r4Edge");
    end

    // Bypass load into pulse mode R=3 at the terminal cycle.
    repeat (4) expectNext(1'b0, "preBypass");
    applyStimulus(1'b1, 1'b1, 9'd3, 1'b1);
    eClk   = ~eClk;
    eRatio = 9'd3;
    expectNext(1'b1, "bypassPulse");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    repeat (2) begin
      eClk = 1'b0;
      repeat (3) expectNext(1'b0, "pulseLow");
      eClk = 1'b1;
      expectNext(1'b1, "pulseHigh");
    end
    eClk = 1'b0;
    repeat (3) expectNext(1'b0, "pulseLow");

    // Back to toggle R=5, then a 3-cycle enable gap at counter=2.
    applyStimulus(1'b1, 1'b1, 9'd5, 1'b0);
    eClk   = 1'b1;
    eRatio = 9'd5;
    expectNext(1'b1, "bypassToggle");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    repeat (2) expectNext(1'b0, "gapPre");
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    repeat (3) expectNext(1'b0, "gapHold");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    repeat (3) expectNext(1'b0, "gapPost");
    eClk = ~eClk;
    expectNext(1'b1, "gapEdge");

    // R=7, then an asynchronous reset at counter=3.
    repeat (5) expectNext(1'b0, "r5Hold");
    applyStimulus(1'b1, 1'b1, 9'd7, 1'b0);
    eClk   = ~eClk;
    eRatio = 9'd7;
    expectNext(1'b1, "bypassR7");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    repeat (3) expectNext(1'b0, "r7Hold");
    eClk   = 1'b1;
    ePend  = 1'b0;
    eRatio = 9'd0;
    pushExpected(1'b0, "asyncReset");
    reset = 1'b0;
    expectNext(1'b0, "resetHold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eClk = ~eClk;
      expectNext(1'b1, "afterReset");
    end

    // Maximum ratio: 512-clock half-periods.
    applyStimulus(1'b1, 1'b1, 9'd511, 1'b0);
    eClk   = ~eClk;
    eRatio = 9'd511;
    expectNext(1'b1, "bypassR511");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    repeat (2) begin
      repeat (511) expectNext(1'b0, "r511Hold");
      eClk = ~eClk;
      expectNext(1'b1, "r511Edge");
    end

    // Load while disabled, pulse R=0 runs constantly high, disable forces low.
    applyStimulus(1'b0, 1'b1, 9'd0, 1'b1);
    eRatio = 9'd0;
    expectNext(1'b0, "disabledApply");
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    eClk = 1'b0;
    expectNext(1'b0, "disabledPulseLow");
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    eClk = 1'b1;
    repeat (3) expectNext(1'b1, "pulseR0");
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    eClk = 1'b0;
    expectNext(1'b0, "pulseDisabled");

    if (sbQueue.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sbQueue.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Runtime-programmable clock divider, the parametrised successor to the fixed divider in the RFID tag's digital core. It produces a divided clock in either 50%-duty toggle mode or single-cycle pulse mode, with a divide ratio that can be reloaded at run time. Ratio and mode changes take effect only at period boundaries, so the output never glitches. It sits between the tag's oscillator clock and the baseband encoder/decoder timing logic; `tick` is provided for logic that must stay on the undivided clock.

## Interface
- `CNT_WIDTH`, 9: width of the counter and of the ratio fields.
- `RESET_RATIO`, 0: value of `ratio_active` and of the pending ratio after reset. With 0, the block divides by 2 in toggle mode.
- `INIT_LEVEL`, 1'b1: reset value of `clk_div`.
- `clock` input 1: the single clock; every register updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enabled` input 1: high = count; low = counter and `clk_div` hold.
- `div_ratio` input CNT_WIDTH: requested terminal count R.
- `mode_sel` input 1: requested mode; 0 = toggle, 1 = pulse.
- `load` input 1: one-cycle strobe that captures `div_ratio` and `mode_sel` as pending.
- `clk_div` output 1: divided clock, registered.
- `tick` output 1: one-cycle strobe, registered, asserted in the same cycle as each `clk_div` update event.
- `ratio_active` output CNT_WIDTH: terminal count currently in use.
- `pending` output 1: a loaded ratio/mode is waiting for a boundary.

## Operation
- **Registers:** counter, `ratio_active`, `mode_active`, `pend_ratio`, `pend_mode`, `pending`, `clk_div`, `tick`.
- **Reset (async, `reset`=0):**
  - counter=0, `ratio_active`=`pend_ratio`=RESET_RATIO, `mode_active`=`pend_mode`=0.
  - `pending`=0, `clk_div`=INIT_LEVEL, `tick`=0.
  - Reset asserted mid-period aborts the period immediately; no output event is produced.
- **Terminal condition:** T = `enabled` & (counter == `ratio_active`).
- **Counting (`enabled`=1):**
  - If not T: counter <= counter+1.
  - If T: counter <= 0 (the boundary).
  - The counter never exceeds `ratio_active`, so no wrap through 2^CNT_WIDTH occurs.
- **Toggle mode (`mode_active`=0):**
  - On T: `clk_div` <= ~`clk_div`, `tick` <= 1.
  - Half-period = R+1 clocks; full period = 2(R+1) clocks; duty is exactly 50%.
- **Pulse mode (`mode_active`=1):**
  - `clk_div` <= T every cycle, so it is high for exactly one cycle per R+1 clocks.
  - `tick` <= T.
  - R=0 gives `clk_div` constantly 1 while enabled.
- **Load:**
  - `load`=1: `pend_ratio` <= `div_ratio`, `pend_mode` <= `mode_sel`, `pending` <= 1.
  - A second `load` before the apply overwrites the pending values.
- **Apply at boundary:**
  - On T with `pending`=1: `ratio_active` and `mode_active` take the pending values, `pending` <= 0.
  - If `load` and T occur in the same cycle, `div_ratio`/`mode_sel` bypass straight to active at this boundary and `pending` stays 0.
- **Disabled (`enabled`=0):**
  - counter and `clk_div` hold; `tick`=0.
  - If `pending`=1 (or `load`=1): the values are applied on that edge, counter <= 0, `pending` <= 0.
  - In pulse mode `clk_div` is forced to 0 while disabled.
- **Mode switch at a boundary:**
  - Toggle→pulse: `clk_div` follows the pulse rule from the next cycle.
  - Pulse→toggle: `clk_div` toggles from its value at the boundary.

## Timing
- **Latency:** `clk_div` and `tick` change on the edge at which T is sampled true. Both are registered; there are no combinational paths from inputs to outputs.
- **First event:** after reset release with `enabled`=1 and R active, the first `clk_div` event occurs on the (R+1)th enabled rising edge.
- **Apply time:** a loaded ratio takes effect on the first boundary at or after the `load` edge. The first period at the new ratio starts at counter=0.
- **Enable gaps:** `enabled` deasserted mid-count stretches the period by exactly the number of disabled cycles. The count is not lost.

## Test plan
- Reset, `enabled`=1, R=0, toggle → `clk_div` 1,0,1,0… toggling every clock, `tick` high every cycle, reset level = INIT_LEVEL.
- `load` R=4 mid-period of R=2, toggle → current half-period finishes at 3 clocks, then half-periods of 5 clocks; `pending` is 1 from the `load` edge until the boundary.
- `load` R=3, `mode_sel`=1 at the terminal cycle (bypass) → from the next period, `clk_div` is high for 1 cycle every 4 clocks; `pending` never asserts.
- R=5 toggle, `enabled` low for 3 cycles at counter=2 → half-period measures 9 clocks, `clk_div` holds, `tick`=0 during the gap.
- `reset` asserted at counter=3 of R=7 → all outputs return to reset values asynchronously; after release, the first toggle occurs on the 1st enabled edge (RESET_RATIO=0).
- R=2^CNT_WIDTH−1 (511), toggle → half-period of 512 clocks, with no counter overflow.
